// File: rtl/sr_fifo_arbiter.sv
// Shares one registered-read sr_fifo between NUM_REQ round-robin writers and one
// valid/ready consumer; at most one FIFO operation is issued per cycle.
module sr_fifo_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ADDR_WIDTH:0]           count,
  output logic                          fifo_we,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          fifo_re,
  input  logic [DATA_WIDTH-1:0]         fifo_rd_data
);

  localparam int                  PTR_W   = $clog2(NUM_REQ);
  localparam int                  DEPTH_I = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH   = DEPTH_I[ADDR_WIDTH:0];

  typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_e;
  typedef enum logic {LAST_READ, LAST_WRITE} last_e;

  logic [ADDR_WIDTH:0] r_count;
  logic                r_out_valid;
  logic [PTR_W-1:0]    r_rr_ptr;
  last_e               r_last_op;

  logic [PTR_W-1:0]    w_winner;
  logic                w_found;
  logic                w_can_write;
  logic                w_can_read;
  op_e                 w_op;
  logic [PTR_W-1:0]    w_rr_next;

  function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Round-robin scan starting at r_rr_ptr; the first requester found wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[wrap_idx(int'(r_rr_ptr), k)]) begin
        w_found  = 1'b1;
        w_winner = wrap_idx(int'(r_rr_ptr), k);
      end
    end
  end

  // NOTE: reset also gates eligibility so grant/fifo_we/fifo_re read 0 while reset is held.
  assign w_can_write = reset && w_found && (r_count < DEPTH);
  assign w_can_read  = reset && (r_count != '0) && (!r_out_valid || out_ready);

  // Next-state: pick the single operation for this cycle; contention alternates.
  always_comb begin
    w_op = OP_IDLE;
    if (w_can_write && w_can_read)
      w_op = (r_last_op == LAST_WRITE) ? OP_READ : OP_WRITE;
    else if (w_can_write)
      w_op = OP_WRITE;
    else if (w_can_read)
      w_op = OP_READ;
    w_rr_next = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
  end

  always_comb begin
    grant      = '0;
    fifo_we    = 1'b0;
    fifo_re    = 1'b0;
    fifo_wdata = req_data[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
    if (w_op == OP_WRITE) begin
      grant[w_winner] = 1'b1;
      fifo_we         = 1'b1;
    end
    if (w_op == OP_READ) fifo_re = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
      r_last_op   <= LAST_READ;
    end else begin
      case (w_op)
        OP_WRITE: begin
          r_count   <= r_count + 1'b1;
          r_rr_ptr  <= w_rr_next;
          r_last_op <= LAST_WRITE;
        end
        OP_READ: begin
          r_count     <= r_count - 1'b1;
          r_out_valid <= 1'b1;
          r_last_op   <= LAST_READ;
        end
        default: ;
      endcase
      // A consumed word with no replacement read leaves out_data empty.
      if (w_op != OP_READ && r_out_valid && out_ready) r_out_valid <= 1'b0;
    end
  end

  assign count     = r_count;
  assign out_valid = r_out_valid;
  assign out_data  = fifo_rd_data;

endmodule

// File: doc/sr_fifo_arbiter.md
Name: sr_fifo_arbiter

Overview:
- Controller that shares one sr_fifo instance between NUM_REQ write requesters and a single consumer.
- Round-robin arbitration on the write side; valid/ready handshake on the read side.
- Tracks occupancy so the FIFO is never written when full or read when empty.
- Never asserts FIFO write and read in the same cycle, because the FIFO ignores simultaneous operations.

Parameters:
- DATA_WIDTH, 32, width of each data word; must match the attached FIFO.
- ADDR_WIDTH, 3, FIFO address width; FIFO depth DEPTH = 2**ADDR_WIDTH.
- NUM_REQ, 4, number of write requesters (2..16).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset; shared with the attached FIFO
- req  in  NUM_REQ  req[i] high: requester i has a word to write; held until granted
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- grant  out  NUM_REQ  one-hot, combinational; grant[i] high means requester i's word is written at this clock edge
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- out_data  out  DATA_WIDTH  consumer data; wired directly from fifo_rd_data
- count  out  ADDR_WIDTH+1  words stored in the FIFO, 0..DEPTH; excludes the word held at out_data
- fifo_we  out  1  to FIFO writeEnable
- fifo_wdata  out  DATA_WIDTH  to FIFO writeData
- fifo_re  out  1  to FIFO readEnable
- fifo_rd_data  in  DATA_WIDTH  from FIFO readData (registered in FIFO, valid the cycle after fifo_re)

Behaviour:
- Registered state:
  - count: reset 0.
  - out_valid: reset 0.
  - rr_ptr, width ceil(log2 NUM_REQ): reset 0.
  - last_op, WRITE or READ: reset READ, so the first contention goes to a write.
- Reset outputs: grant=0, fifo_we=0, fifo_re=0, out_valid=0, count=0, out_data follows FIFO reset value (0).
- Write arbitration, combinational:
  - winner = first index i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - can_write = |req && count < DEPTH.
- Read eligibility: can_read = count > 0 && (!out_valid || out_ready).
- Op select, exactly one or none per cycle:
  - only can_write → WRITE.
  - only can_read → READ.
  - both → the op opposite to last_op (strict alternation under contention).
  - neither → idle.
- WRITE cycle:
  - grant[winner]=1, fifo_we=1, fifo_wdata = req_data slice of winner.
  - At the edge: count+1, rr_ptr ← (winner+1) mod NUM_REQ, last_op ← WRITE.
- READ cycle:
  - fifo_re=1.
  - At the edge: count−1, out_valid ← 1, last_op ← READ.
  - New word appears on out_data in the next cycle (1-cycle latency).
- Consume without READ: out_valid && out_ready → out_valid ← 0.
- Consume with READ in the same cycle: out_valid stays 1 and the new word replaces the old one at the edge (back-to-back throughput).
- out_data must stay stable while out_valid=1 and out_ready=0; guaranteed because no read issues in that state.
- Full (count=DEPTH): grant=0, requests stall; rr_ptr unchanged.
- Empty (count=0): fifo_re=0; out_valid drops after the held word is consumed.
- Wrap-around: rr_ptr NUM_REQ−1 → 0. Count never exceeds DEPTH or goes below 0.
- Idle cycles and stalls: rr_ptr and last_op unchanged.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronous).
  - An in-flight grant is lost; requesters must re-request.
  - The FIFO, on the same reset, clears its pointers.
- Maximum sustained rates: writes alone 1/cycle; reads alone 1/cycle; mixed traffic 1 write + 1 read per 2 cycles.

Test Plan:
- Single writer:
  - Stimulus: req=0001 with data 0xA0..0xA7 for 8 words, out_ready=0.
  - Response: grant[0] pulses 8 times, count=8. A 9th request is not granted while count=8.
- Round-robin:
  - Stimulus: req=1111 held, data i=0x10+i, out_ready=0.
  - Response: grant order 0,1,2,3,0,1,2,3; count reaches 8 at cycle 8.
- Drain:
  - Stimulus: FIFO holds 0x10..0x13, no req, out_ready=1.
  - Response: out_data 0x10,0x11,0x12,0x13 on consecutive cycles; out_valid falls the cycle after the last word; count=0.
- Contention:
  - Stimulus: req[2]=1 continuously, count=3, out_ready=1.
  - Response: fifo_we and fifo_re alternate, never both high, first op WRITE; count oscillates 4,3,4,3.
- Backpressure:
  - Stimulus: out_valid=1 with out_data=0x55, out_ready=0 for 5 cycles.
  - Response: out_data stays 0x55; fifo_re=0; writes continue until count=8.
- Mid-operation reset:
  - Stimulus: reset low for 1 cycle at count=5, out_valid=1.
  - Response: count=0, out_valid=0, grant=0 immediately; after release, the first write lands at FIFO address 0 and reads back correctly.
